// File: rtl/digital_mem_arbiter.sv
// Round-robin arbiter sharing the digital_mem_* port between two bus masters.
// It allows one outstanding transaction at a time, uses registered memory-side outputs, and aborts a stalled access after a timeout.
module digital_mem_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [3:0]      m0_be,
    output logic            m0_done,
    output logic            m0_err,
    output logic [XLEN-1:0] m0_rdata,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [3:0]      m1_be,
    output logic            m1_done,
    output logic            m1_err,
    output logic [XLEN-1:0] m1_rdata,

    output logic [XLEN-1:0] digital_mem_addr,
    output logic            digital_mem_write_en,
    output logic            digital_mem_read_en,
    output logic [3:0]      digital_mem_byte_size,
    output logic [XLEN-1:0] digital_mem_wdata,
    input  logic [XLEN-1:0] digital_mem_data,
    input  logic            digital_mem_ready,

    output logic            busy,
    output logic            grant_id
);

    localparam int unsigned BE_W  = 4;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              prio_q, prio_d;

    logic [XLEN-1:0]   addr_d, wdata_d, rdata0_d, rdata1_d;
    logic [BE_W-1:0]   be_d;
    logic              wen_d, ren_d, done0_d, done1_d, err0_d, err1_d;
    logic              busy_d, grant_d;

    logic              win_c;
    logic              timeout_hit_c;

    // prio_q names the requester that wins a tie; it flips only on a grant
    assign win_c         = m1_req & (~m0_req | prio_q);
    assign timeout_hit_c = (TIMEOUT_CYCLES != 0) &&
                           ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= IDLE;
            cnt_q                 <= '0;
            prio_q                <= 1'b0;
            digital_mem_addr      <= '0;
            digital_mem_wdata     <= '0;
            digital_mem_byte_size <= '0;
            digital_mem_write_en  <= 1'b0;
            digital_mem_read_en   <= 1'b0;
            m0_done               <= 1'b0;
            m1_done               <= 1'b0;
            m0_err                <= 1'b0;
            m1_err                <= 1'b0;
            m0_rdata              <= '0;
            m1_rdata              <= '0;
            busy                  <= 1'b0;
            grant_id              <= 1'b0;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            prio_q                <= prio_d;
            digital_mem_addr      <= addr_d;
            digital_mem_wdata     <= wdata_d;
            digital_mem_byte_size <= be_d;
            digital_mem_write_en  <= wen_d;
            digital_mem_read_en   <= ren_d;
            m0_done               <= done0_d;
            m1_done               <= done1_d;
            m0_err                <= err0_d;
            m1_err                <= err1_d;
            m0_rdata              <= rdata0_d;
            m1_rdata              <= rdata1_d;
            busy                  <= busy_d;
            grant_id              <= grant_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prio_d   = prio_q;
        addr_d   = digital_mem_addr;
        wdata_d  = digital_mem_wdata;
        be_d     = digital_mem_byte_size;
        wen_d    = digital_mem_write_en;
        ren_d    = digital_mem_read_en;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = m0_rdata;
        rdata1_d = m1_rdata;
        busy_d   = busy;
        grant_d  = grant_id;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    grant_d = win_c;
                    prio_d  = ~win_c;
                    busy_d  = 1'b1;
                    addr_d  = win_c ? m1_addr  : m0_addr;
                    wdata_d = win_c ? m1_wdata : m0_wdata;
                    be_d    = win_c ? m1_be    : m0_be;
                    wen_d   = win_c ? m1_we    : m0_we;
                    ren_d   = ~wen_d;
                end
            end

            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (digital_mem_ready || timeout_hit_c) begin
                    state_d = DONE;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = '0;
                    wen_d   = 1'b0;
                    ren_d   = 1'b0;
                    done0_d = ~grant_id;
                    done1_d = grant_id;
                    // a ready on the final allowed cycle still counts as success
                    if (digital_mem_ready) begin
                        if (digital_mem_read_en) begin
                            if (grant_id) rdata1_d = digital_mem_data;
                            else          rdata0_d = digital_mem_data;
                        end
                    end else begin
                        err0_d = ~grant_id;
                        err1_d = grant_id;
                        if (grant_id) rdata1_d = '0;
                        else          rdata0_d = '0;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                wen_d   = 1'b0;
                ren_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_digital_mem_arbiter.sv
// Directed bench for digital_mem_arbiter (TIMEOUT_CYCLES=8).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_digital_mem_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            m0_req, m0_we, m1_req, m1_we;
    logic [XLEN-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]      m0_be, m1_be;
    logic            m0_done, m0_err, m1_done, m1_err;
    logic [XLEN-1:0] m0_rdata, m1_rdata;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_data;
    logic            mem_wen, mem_ren, mem_ready;
    logic [3:0]      mem_bsz;
    logic            busy, grant_id;

    int total = 0;
    int bad   = 0;

    digital_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .digital_mem_addr(mem_addr), .digital_mem_write_en(mem_wen),
        .digital_mem_read_en(mem_ren), .digital_mem_byte_size(mem_bsz),
        .digital_mem_wdata(mem_wdata), .digital_mem_data(mem_data),
        .digital_mem_ready(mem_ready), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
        mem_data = '0; mem_ready = 0;

        // reset state
        step(); step();
        chk("rst_ren", 32'(mem_ren), 0);
        chk("rst_wen", 32'(mem_wen), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_done", 32'({m0_done, m1_done}), 0);
        chk("rst_addr", mem_addr, 0);
        rst = 1'b0;

        // 1: m0 read, ready two cycles after read_en
        m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_be = 4'hF;
        step();
        chk("t1_ren_c1", 32'(mem_ren), 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_bsz", 32'(mem_bsz), 32'hF);
        chk("t1_grant", 32'(grant_id), 0);
        chk("t1_busy", 32'(busy), 1);
        m0_req = 0;
        step();
        chk("t1_ren_c2", 32'(mem_ren), 1);
        chk("t1_done_early", 32'(m0_done), 0);
        mem_ready = 1; mem_data = 32'hDEADBEEF;
        step();
        chk("t1_ren_off", 32'(mem_ren), 0);
        chk("t1_m0_done", 32'(m0_done), 1);
        chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        chk("t1_err", 32'(m0_err), 0);
        chk("t1_m1_done", 32'(m1_done), 0);
        chk("t1_addr_clr", mem_addr, 0);
        chk("t1_busy_done", 32'(busy), 1);
        mem_ready = 0;
        step();
        chk("t1_done_pulse", 32'(m0_done), 0);
        chk("t1_busy_idle", 32'(busy), 0);
        chk("t1_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // 2: both requesting, held; reset first so m0 leads
        rst = 1; step(); rst = 0;
        m0_req = 1; m0_addr = 32'h200; m1_req = 1; m1_we = 0; m1_addr = 32'h300; m1_be = 4'hF;
        mem_ready = 1; mem_data = 32'hA5A50001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_grant", 32'(grant_id), 32'(i % 2));
            chk("t2_ren", 32'(mem_ren), 1);
            chk("t2_addr", mem_addr, (i % 2 == 1) ? 32'h300 : 32'h200);
            step();
            chk("t2_done_owner", 32'({m1_done, m0_done}), (i % 2 == 1) ? 32'd2 : 32'd1);
            chk("t2_gap_done", 32'(mem_ren), 0);
            step();
            chk("t2_gap_idle", 32'({mem_ren, mem_wen}), 0);
        end
        m0_req = 0; m1_req = 0; mem_ready = 0;
        chk("t2_m1_rdata", m1_rdata, 32'hA5A50001);

        // 3: m1 write, ready in the same cycle as write_en
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_be = 4'b0011;
        step();
        chk("t3_wen", 32'(mem_wen), 1);
        chk("t3_ren", 32'(mem_ren), 0);
        chk("t3_addr", mem_addr, 32'h20);
        chk("t3_wdata", mem_wdata, 32'h12345678);
        chk("t3_bsz", 32'(mem_bsz), 32'h3);
        chk("t3_grant", 32'(grant_id), 1);
        m1_req = 0; mem_ready = 1; mem_data = 32'hFFFF0000;
        step();
        chk("t3_wen_off", 32'(mem_wen), 0);
        chk("t3_m1_done", 32'(m1_done), 1);
        chk("t3_m0_done", 32'(m0_done), 0);
        chk("t3_err", 32'(m1_err), 0);
        chk("t3_rdata_keep", m1_rdata, 32'hA5A50001);
        mem_ready = 0;
        step();

        // 4: timeout after 8 ACCESS cycles, then a normal access
        m0_req = 1; m0_we = 0; m0_addr = 32'h40; m0_be = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            m0_req = 0;
            chk("t4_ren_held", 32'(mem_ren), 1);
        end
        step();
        chk("t4_ren_off", 32'(mem_ren), 0);
        chk("t4_done", 32'(m0_done), 1);
        chk("t4_err", 32'(m0_err), 1);
        chk("t4_rdata", m0_rdata, 0);
        step();
        chk("t4_err_pulse", 32'({m0_done, m0_err}), 0);
        m1_req = 1; m1_we = 0; m1_addr = 32'h44;
        step();
        chk("t4_next_ren", 32'(mem_ren), 1);
        m1_req = 0; mem_ready = 1; mem_data = 32'h0BADF00D;
        step();
        chk("t4_next_done", 32'({m1_done, m1_err}), 32'd2);
        chk("t4_next_rdata", m1_rdata, 32'h0BADF00D);
        mem_ready = 0;
        step();

        // 5: reset during ACCESS; tie afterwards must go to m0
        m0_req = 1; m0_we = 0; m0_addr = 32'h80;
        step();
        chk("t5_ren", 32'(mem_ren), 1);
        m0_req = 0; rst = 1;
        step();
        chk("t5_ren_rst", 32'(mem_ren), 0);
        chk("t5_busy_rst", 32'(busy), 0);
        chk("t5_done_rst", 32'(m0_done), 0);
        rst = 0; mem_ready = 1;
        step();
        chk("t5_no_done", 32'({m0_done, m1_done}), 0);
        mem_ready = 0;
        m0_req = 1; m1_req = 1; m0_addr = 32'h90; m1_addr = 32'h94;
        step();
        chk("t5_tie_grant", 32'(grant_id), 0);
        chk("t5_tie_addr", mem_addr, 32'h90);
        m0_req = 0; m1_req = 0; mem_ready = 1;
        step();
        chk("t5_tie_done", 32'({m1_done, m0_done}), 32'd1);
        mem_ready = 0;
        step();

        // 6: m1 drops req mid-ACCESS
        m1_req = 1; m1_we = 0; m1_addr = 32'hC0;
        step();
        chk("t6_grant", 32'(grant_id), 1);
        m1_req = 0;
        step();
        chk("t6_ren_held", 32'(mem_ren), 1);
        mem_ready = 1; mem_data = 32'hCAFE0006;
        step();
        chk("t6_done", 32'(m1_done), 1);
        chk("t6_rdata", m1_rdata, 32'hCAFE0006);
        mem_ready = 0;
        step();
        chk("t6_done_once", 32'(m1_done), 0);
        step();
        chk("t6_idle", 32'({busy, mem_ren, m1_done}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
